lfsr_prng_gen: RTL and testbench
================================

// Module: lfsr_prng_gen
// PURPOSE
//  Parametrised Fibonacci XNOR LFSR pseudo-random word generator for the mesh traffic generators.
//  Generalises the fixed 8-bit lfsr7: width, tap mask and reset seed are parameters; the seed is runtime-loadable.
//  Advances STEPS shifts per emitted word and delivers each word over a valid/ready handshake to the packet injector.
//  Flags all-ones (lockup) seed loads and pulses wrap when the sequence returns to its start value.
// PARAMETERS
//  WIDTH  8      LFSR and output word width, 2..32
//  TAPS   8'h14  feedback tap mask, WIDTH bits; bit i set = state[i] feeds the XNOR
//  SEED   0      reset/recovery state, WIDTH bits; must not be all-ones
//  STEPS  1      shifts per emitted word, 1..WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  en         in   1      shift enable; acts only in GEN state
//  seed_load  in   1      load seed_in this cycle
//  seed_in    in   WIDTH  runtime seed
//  out_data   out  WIDTH  generated word, stable while out_valid=1
//  out_valid  out  1      word available
//  out_ready  in   1      consumer accepts; transfer = out_valid & out_ready at a rising edge
//  wrap       out  1      1-cycle pulse: state returned to the reference value
//  lockup     out  1      1-cycle pulse: all-ones seed_in rejected, SEED substituted
// BEHAVIOUR
//  Reset (rst=0, async): state=SEED, ref=SEED, step_cnt=0, FSM=GEN; out_data=0, out_valid=0, wrap=0, lockup=0.
//  Next state: nxt = {state[WIDTH-2:0], fb}, where fb = ~^(state & TAPS) (XNOR reduce).
//  FSM, 2 states:
//   GEN:  en=1 -> state<=nxt, step_cnt++. When step_cnt==STEPS-1 and en=1:
//         out_data<=nxt, out_valid<=1, step_cnt<=0, go to HOLD. en=0 -> everything frozen.
//   HOLD: state, step_cnt and out_data frozen; en ignored. Transfer -> out_valid<=0, go to GEN.
//  Latency: the first word is valid STEPS en-cycles after reset release.
//   With en=1 and out_ready=1 held, one word per STEPS+1 cycles; the accept cycle does not shift.
//  seed_load (priority over all other actions, in any state):
//   state<=seed_in, ref<=seed_in, step_cnt<=0, out_valid<=0, FSM<=GEN.
//   A word held in HOLD is discarded, even if out_ready=1 in the same cycle (no transfer counted).
//   If seed_in is all-ones (XNOR lockup state): load SEED into state and ref instead, and lockup<=1 for one cycle.
//  wrap: registered; =1 in the cycle after a shift whose nxt == ref; otherwise 0. A seed_load never asserts wrap.
//   For maximal TAPS, wrap pulses every 2^WIDTH-1 shifts.
//  lockup and wrap default to 0 each cycle and never stick.
//  Reset mid-operation: all registers return to reset values immediately; a pending word is lost.
// TESTING (WIDTH=8, TAPS=8'h14, SEED=0 unless stated)
//  1 STEPS=1, en=1, out_ready=1 after reset -> accepted words 0x01,0x03,0x07,0x0E,0x1C,0x39;
//    out_valid high every second cycle.
//  2 STEPS=1, out_ready=0 for 6 cycles -> out_data holds 0x01, out_valid stays 1;
//    raising ready gives 0x01 then 0x03.
//  3 STEPS=4, en=1 -> first word 0x0E, 4 cycles after reset; en toggled 0 mid-GEN -> word delayed by the en=0 cycles.
//  4 HOLD with 0x01, seed_load=1, seed_in=0x1C, out_ready=1 in same cycle -> no transfer;
//    next word 0x39; out_valid=0 for one cycle.
//  5 seed_load, seed_in=0xFF -> lockup=1 for one cycle, state=0x00, next word 0x01.
//  6 WIDTH=4, TAPS=4'hC, SEED=0, STEPS=1, ready=1 -> wrap pulses after shift 15 and 30;
//    rst=0 asserted mid-HOLD -> out_valid=0 immediately.

Source files
------------

// File: rtl/lfsr_prng_gen.sv
// Parametrised Fibonacci XNOR LFSR word generator with a valid/ready output.
// It emits one word every STEPS enabled shifts, flags all-ones seed loads and pulses wrap when the sequence repeats.
module lfsr_prng_gen #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'h14,
    parameter logic [WIDTH-1:0] SEED = '0,
    parameter int              STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic             lockup,
    output logic             dbg_state
);

    // Handshake: a word moves when out_valid and out_ready are both high at a rising
    // edge; out_data stays stable while out_valid is high, and seed_load cancels it.

    typedef enum logic {GEN = 1'b0, HOLD = 1'b1} fsm_t;

    localparam int CW = $clog2(STEPS) + 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    fsm_t             fsm, fsm_nxt;
    logic [WIDTH-1:0] state, ref_val, nxt;
    logic [CW-1:0]    step_cnt;
    logic             fb, do_shift, emit, xfer, seed_bad;

    assign fb        = ~^(state & TAPS);
    assign nxt       = {state[WIDTH-2:0], fb};
    assign seed_bad  = (seed_in == '1);
    assign dbg_state = (fsm == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm <= GEN;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt  = fsm;
        do_shift = 1'b0;
        emit     = 1'b0;
        xfer     = 1'b0;
        if (seed_load) begin
            fsm_nxt = GEN;
        end else begin
            case (fsm)
                GEN: begin
                    if (en) begin
                        do_shift = 1'b1;
                        if (step_cnt == LAST) begin
                            emit    = 1'b1;
                            fsm_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        xfer    = 1'b1;
                        fsm_nxt = GEN;
                    end
                end
                default: fsm_nxt = GEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEED;
            ref_val   <= SEED;
            step_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            lockup    <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (seed_load) begin
                // All-ones is the XNOR lockup state; fall back to SEED instead.
                state     <= seed_bad ? SEED : seed_in;
                ref_val   <= seed_bad ? SEED : seed_in;
                lockup    <= seed_bad;
                step_cnt  <= '0;
                out_valid <= 1'b0;
            end else begin
                if (do_shift) begin
                    state    <= nxt;
                    wrap     <= (nxt == ref_val);
                    step_cnt <= emit ? '0 : step_cnt + CW'(1);
                end
                if (emit) begin
                    out_data  <= nxt;
                    out_valid <= 1'b1;
                end else if (xfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Bench for lfsr_prng_gen: vector table, hand-written corner sequences and a
// randomized run scored against a bit-level LFSR reference model.
module tb_lfsr_prng_gen;

    logic       clk;
    logic       rst_ab, rst_c;

    logic       en_v[2], ready_v[2], load_v[2];
    logic [7:0] seed_v[2];
    logic [7:0] data_v[2];
    logic       valid_v[2], wrap_v[2], lock_v[2], dbg_v[2];

    logic       en_c, ready_c, load_c;
    logic [3:0] seed_c, data_c;
    logic       valid_c, wrap_c, lock_c, dbg_c;

    int tests = 0;
    int fails = 0;

    lfsr_prng_gen #(.WIDTH(8), .TAPS(8'h14), .SEED(8'h00), .STEPS(1)) u_a (
        .clk(clk), .rst(rst_ab), .en(en_v[0]), .seed_load(load_v[0]), .seed_in(seed_v[0]),
        .out_data(data_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0]),
        .wrap(wrap_v[0]), .lockup(lock_v[0]), .dbg_state(dbg_v[0]));

    lfsr_prng_gen #(.WIDTH(8), .TAPS(8'h14), .SEED(8'h00), .STEPS(4)) u_b (
        .clk(clk), .rst(rst_ab), .en(en_v[1]), .seed_load(load_v[1]), .seed_in(seed_v[1]),
        .out_data(data_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1]),
        .wrap(wrap_v[1]), .lockup(lock_v[1]), .dbg_state(dbg_v[1]));

    lfsr_prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h0), .STEPS(1)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .seed_load(load_c), .seed_in(seed_c),
        .out_data(data_c), .out_valid(valid_c), .out_ready(ready_c),
        .wrap(wrap_c), .lockup(lock_c), .dbg_state(dbg_c));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps, input int w);
        int ones;
        logic [31:0] mask;
        ones = 0;
        for (int i = 0; i < w; i++) if (s[i] && taps[i]) ones++;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return ((s << 1) | ((ones % 2 == 0) ? 32'd1 : 32'd0)) & mask;
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsr_step(r, 32'h14, 8);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset_ab();
        for (int i = 0; i < 2; i++) begin
            en_v[i] = 1'b0; ready_v[i] = 1'b0; load_v[i] = 1'b0; seed_v[i] = 8'h00;
        end
        rst_ab = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_valid", i), valid_v[i], 1'b0);
            check($sformatf("rst%0d_data", i), data_v[i], 8'h00);
            check($sformatf("rst%0d_wrap", i), wrap_v[i], 1'b0);
            check($sformatf("rst%0d_lock", i), lock_v[i], 1'b0);
        end
        rst_ab = 1'b1;
    endtask

    typedef struct {
        bit         rst_before;
        logic       en;
        logic       ready;
        logic       load;
        logic [7:0] seed;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_lock;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input logic e, input logic rd, input logic ld,
                                input logic [7:0] sd, input logic ev, input logic [7:0] ed, input logic el);
        vec_t v;
        v.rst_before = r; v.en = e; v.ready = rd; v.load = ld; v.seed = sd;
        v.exp_valid = ev; v.exp_data = ed; v.exp_lock = el;
        vecs.push_back(v);
    endfunction

    task automatic run_random(input int idx, input int steps, input int ncycles);
        logic [7:0] m_state, m_ref, m_base, m_data, s;
        logic       m_valid, m_wrap, m_lock;
        int         m_cnt;
        logic [7:0] exp_q[$];
        do_reset_ab();
        m_state = 8'h00; m_ref = 8'h00; m_base = 8'h00; m_data = 8'h00;
        m_valid = 1'b0; m_wrap = 1'b0; m_lock = 1'b0; m_cnt = 0;
        for (int c = 0; c < ncycles; c++) begin
            en_v[idx]    = ($urandom_range(0, 3) != 0);
            ready_v[idx] = 1'($urandom_range(0, 1));
            load_v[idx]  = ($urandom_range(0, 15) == 0);
            seed_v[idx]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            if (valid_v[idx] && ready_v[idx] && !load_v[idx]) begin
                if (exp_q.size() == 0) check("sb_spurious", 1'b1, 1'b0);
                else check("sb_word", data_v[idx], exp_q.pop_front());
            end
            m_wrap = 1'b0;
            m_lock = 1'b0;
            if (load_v[idx]) begin
                s = (seed_v[idx] == 8'hFF) ? 8'h00 : seed_v[idx];
                m_lock = (seed_v[idx] == 8'hFF);
                m_state = s; m_ref = s; m_base = s; m_cnt = 0; m_valid = 1'b0;
                exp_q.delete();
            end else if (m_valid) begin
                if (ready_v[idx]) m_valid = 1'b0;
            end else if (en_v[idx]) begin
                m_state = 8'(lfsr_step(32'(m_state), 32'h14, 8));
                m_wrap = (m_state == m_ref);
                m_cnt++;
                if (m_cnt == steps) begin
                    m_data = 8'(lfsr_adv(32'(m_base), steps));
                    m_base = m_data;
                    m_valid = 1'b1;
                    m_cnt = 0;
                    exp_q.push_back(m_data);
                end
            end
            @(negedge clk);
            check($sformatf("rnd%0d_valid", idx), valid_v[idx], m_valid);
            check($sformatf("rnd%0d_data", idx), data_v[idx], m_data);
            check($sformatf("rnd%0d_wrap", idx), wrap_v[idx], m_wrap);
            check($sformatf("rnd%0d_lock", idx), lock_v[idx], m_lock);
        end
        en_v[idx] = 1'b0; ready_v[idx] = 1'b0; load_v[idx] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          wraps, shifts;
        logic        c_valid;
        logic [3:0]  c_state;
        logic [7:0]  words[6];
        logic        en_pat[7];

        rst_c = 1'b0; en_c = 1'b0; ready_c = 1'b0; load_c = 1'b0; seed_c = 4'h0;
        do_reset_ab();

        // Free-running with ready high: a word every second cycle.
        words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07;
        words[3] = 8'h0E; words[4] = 8'h1C; words[5] = 8'h39;
        for (int k = 0; k < 6; k++) begin
            add(k == 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, words[k], 1'b0);
            add(1'b0,   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, words[k], 1'b0);
        end
        // Back-pressure: word holds while ready is low.
        for (int k = 0; k < 6; k++) add(k == 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
        // seed_load in HOLD with ready high discards the held word.
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 8'h1C, 1'b0, 8'h01, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h39, 1'b0);
        // All-ones seed is rejected and SEED substituted.
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h39, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h39, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset_ab();
            en_v[0] = vecs[k].en; ready_v[0] = vecs[k].ready;
            load_v[0] = vecs[k].load; seed_v[0] = vecs[k].seed;
            @(negedge clk);
            check($sformatf("vec%0d_valid", k), valid_v[0], vecs[k].exp_valid);
            check($sformatf("vec%0d_data", k), data_v[0], vecs[k].exp_data);
            check($sformatf("vec%0d_lock", k), lock_v[0], vecs[k].exp_lock);
            check($sformatf("vec%0d_wrap", k), wrap_v[0], 1'b0);
        end
        en_v[0] = 1'b0; ready_v[0] = 1'b0; load_v[0] = 1'b0;

        // STEPS=4: first word after four enabled cycles.
        do_reset_ab();
        en_v[1] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("s4_valid_c%0d", c), valid_v[1], (c == 4));
        end
        check("s4_data", data_v[1], 8'h0E);

        // STEPS=4 with en dropped mid-GEN: word delayed by the idle cycles.
        do_reset_ab();
        en_pat[0] = 1; en_pat[1] = 1; en_pat[2] = 0; en_pat[3] = 0;
        en_pat[4] = 0; en_pat[5] = 1; en_pat[6] = 1;
        for (int c = 0; c < 7; c++) begin
            en_v[1] = en_pat[c];
            @(negedge clk);
            check($sformatf("s4en_valid_c%0d", c), valid_v[1], (c == 6));
        end
        check("s4en_data", data_v[1], 8'h0E);
        en_v[1] = 1'b0;

        // Randomized traffic against the reference model.
        run_random(0, 1, 400);
        run_random(1, 4, 400);

        // 4-bit maximal LFSR: wrap after shifts 15 and 30.
        rst_c = 1'b0;
        @(negedge clk);
        check("c_rst_valid", valid_c, 1'b0);
        check("c_rst_wrap", wrap_c, 1'b0);
        rst_c = 1'b1;
        en_c = 1'b1; ready_c = 1'b1;
        wraps = 0; shifts = 0; c_valid = 1'b0; c_state = 4'h0;
        for (int c = 1; c <= 62; c++) begin
            logic shifted;
            shifted = !c_valid;
            if (shifted) begin
                shifts++;
                c_state = 4'(lfsr_step(32'(c_state), 32'hC, 4));
            end
            c_valid = !c_valid;
            @(negedge clk);
            if (wrap_c) wraps++;
            check($sformatf("c_wrap_c%0d", c), wrap_c, shifted && (shifts % 15 == 0));
            check($sformatf("c_valid_c%0d", c), valid_c, c_valid);
            check($sformatf("c_data_c%0d", c), data_c, c_state);
        end
        check("c_wrap_count", 32'(wraps), 32'd2);
        @(negedge clk);
        check("c_hold_valid", valid_c, 1'b1);
        #2 rst_c = 1'b0;
        #1;
        check("c_async_rst_valid", valid_c, 1'b0);
        check("c_async_rst_data", data_c, 4'h0);
        @(negedge clk);
        rst_c = 1'b1;
        en_c = 1'b0; ready_c = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
